// File: rtl/prio_arbiter_rr.sv
// N-channel priority arbiter, fixed (highest index wins) or round-robin, with registered idx/grant.
// Latency: req/mode sampled on a load edge, grant visible one cycle later.
// Backpressure: while valid && !ready the grant register and its mode bit are frozen and req/mode are ignored.
module prio_arbiter_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  // Output register and round-robin state
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_grant;
  logic [W-1:0] r_ptr;
  logic         r_mode;   // mode that produced the grant currently held

  logic         w_accept;
  logic         w_load;
  logic [W-1:0] w_idx_dec;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_start;
  logic         w_found;
  logic [W-1:0] w_win;
  logic [N-1:0] w_onehot;
  int           w_dist;
  int           w_best;

  assign w_accept = r_valid && ready;
  assign w_load   = !r_valid || ready;

  // Channel just served drops to lowest priority; index 0 wraps to N-1.
  assign w_idx_dec = (r_idx == '0) ? W'(N - 1) : (r_idx - W'(1));

  // Forward the pointer update so a load coincident with an accept already
  // searches from the post-accept position (strict rotation under all-ones req).
  assign w_ptr_nxt = (w_accept && r_mode) ? w_idx_dec : r_ptr;

  // Winner search: the set channel closest (downward, with wrap) to the start point.
  // Fixed mode is the same search starting at N-1.
  always_comb begin
    w_start = mode ? w_ptr_nxt : W'(N - 1);
    w_found = 1'b0;
    w_win   = '0;
    w_best  = N;
    w_dist  = 0;
    for (int j = 0; j < N; j++) begin
      if (int'(w_start) >= j) begin
        w_dist = int'(w_start) - j;
      end else begin
        w_dist = int'(w_start) + N - j;
      end
      if (req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win   = W'(j);
        w_found = 1'b1;
      end
    end
  end

  assign w_onehot = w_found ? (N'(1) << w_win) : '0;

  // State update: synchronous reset first, then pointer advance and grant load when the slot is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_grant <= '0;
      r_ptr   <= W'(N - 1);
      r_mode  <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_load) begin
        r_valid <= w_found;
        r_idx   <= w_win;
        r_grant <= w_onehot;
        r_mode  <= mode;
      end
    end
  end

  assign valid = r_valid;
  assign idx   = r_idx;
  assign grant = r_grant;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: directed N=4 scenarios, then N=8 random traffic
// against a behavioural model, with a round-robin starvation bound.
module tb_prio_arbiter_rr;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // N = 4 instance
  logic       rst4_n, m4, rd4, v4;
  logic [3:0] r4, g4;
  logic [1:0] i4;

  // N = 8 instance
  logic       rst8_n, m8, rd8, v8;
  logic [7:0] r8, g8;
  logic [2:0] i8;

  prio_arbiter_rr #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .mode(m4), .req(r4), .ready(rd4),
    .valid(v4), .idx(i4), .grant(g4)
  );

  prio_arbiter_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .mode(m8), .req(r8), .ready(rd8),
    .valid(v8), .idx(i8), .grant(g8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive N=4 inputs, take one edge, return to the falling edge for sampling.
  task automatic step4(input logic [3:0] rq, input logic md, input logic rdy, input logic rstn);
    r4 = rq; m4 = md; rd4 = rdy; rst4_n = rstn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp4(input string tag, input int v, input int i, input int g);
    chk({tag, "_valid"}, int'(v4), v);
    chk({tag, "_idx"},   int'(i4), i);
    chk({tag, "_grant"}, int'(g4), g);
  endtask

  // Behavioural model for N=8
  int mv, mi, mp, mm;

  task automatic model8_edge(input logic [7:0] rq, input logic md, input logic rdy, input logic rstn);
    int st, c;
    bit acc, ld, found;
    if (!rstn) begin
      mv = 0; mi = 0; mp = 7; mm = 0;
    end else begin
      acc = (mv != 0) && rdy;
      ld  = (mv == 0) || rdy;
      if (acc && mm != 0) mp = (mi + 7) % 8;
      if (ld) begin
        mm = int'(md);
        if (rq == 8'h00) begin
          mv = 0; mi = 0;
        end else begin
          st = md ? mp : 7;
          found = 0;
          for (int k = 0; k < 8; k++) begin
            c = (st - k + 8) % 8;
            if (!found && rq[c]) begin
              found = 1;
              mi = c;
            end
          end
          mv = 1;
        end
      end
    end
  endtask

  int rr_exp[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
  int sp_exp[4] = '{3, 1, 3, 1};

  logic [7:0] hold;
  int         fcnt[8];
  logic       g_mode;
  logic       s_v;
  int         s_i;
  bit         acc8, ld8;

  initial begin
    rst8_n = 1'b0; m8 = 1'b0; rd8 = 1'b0; r8 = '0;

    // Reset with requests present
    step4(4'hF, 1'b0, 1'b1, 1'b0);
    step4(4'hF, 1'b0, 1'b1, 1'b0);
    exp4("reset", 0, 0, 0);
    step4(4'hF, 1'b0, 1'b1, 1'b1);
    exp4("post_reset", 1, 3, 8);

    // Fixed-priority sweep
    for (int k = 0; k < 4; k++) begin
      step4(4'(1 << k), 1'b0, 1'b1, 1'b1);
      exp4("fixed_sweep", 1, k, 1 << k);
    end
    step4(4'h0, 1'b0, 1'b1, 1'b1);
    exp4("fixed_empty", 0, 0, 0);

    // Backpressure: grant frozen while ready is low
    step4(4'b0110, 1'b0, 1'b0, 1'b1);
    exp4("bp_load", 1, 2, 4);
    for (int k = 0; k < 3; k++) begin
      step4(4'b0001, 1'b0, 1'b0, 1'b1);
      exp4("bp_stall", 1, 2, 4);
    end
    step4(4'b0001, 1'b0, 1'b1, 1'b1);
    exp4("bp_release", 1, 0, 1);

    // Round-robin with every channel requesting: strict rotation and wrap
    for (int k = 0; k < 8; k++) begin
      step4(4'hF, 1'b1, 1'b1, 1'b1);
      exp4("rr_full", 1, rr_exp[k], 1 << rr_exp[k]);
    end

    // Sparse round-robin, then fixed mode, then back to round-robin
    for (int k = 0; k < 4; k++) begin
      step4(4'b1010, 1'b1, 1'b1, 1'b1);
      exp4("rr_sparse", 1, sp_exp[k], 1 << sp_exp[k]);
    end
    for (int k = 0; k < 3; k++) begin
      step4(4'b1010, 1'b0, 1'b1, 1'b1);
      exp4("sparse_fixed", 1, 3, 8);
    end
    step4(4'b1010, 1'b1, 1'b1, 1'b1);
    exp4("rr_resume0", 1, 3, 8);
    step4(4'b1010, 1'b1, 1'b1, 1'b1);
    exp4("rr_resume1", 1, 1, 2);

    // Reset in the middle of a stall restores the pointer to N-1
    step4(4'hF, 1'b1, 1'b1, 1'b1);
    exp4("mid_a", 1, 0, 1);
    step4(4'hF, 1'b1, 1'b1, 1'b1);
    exp4("mid_b", 1, 3, 8);
    step4(4'hF, 1'b1, 1'b1, 1'b1);
    exp4("mid_c", 1, 2, 4);
    step4(4'hF, 1'b1, 1'b0, 1'b1);
    exp4("mid_stall", 1, 2, 4);
    step4(4'hF, 1'b1, 1'b0, 1'b0);
    exp4("mid_reset", 0, 0, 0);
    step4(4'hF, 1'b1, 1'b1, 1'b1);
    exp4("mid_after", 1, 3, 8);

    // N = 8 randomized regression
    hold = '0;
    g_mode = 1'b0;
    for (int c = 0; c < 8; c++) fcnt[c] = 0;
    rst8_n = 1'b0;
    @(posedge clk);
    model8_edge(r8, m8, rd8, rst8_n);
    @(negedge clk);
    rst8_n = 1'b1;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Compare against the model, then sample the outputs the requesters see.
      chk("r8_valid", int'(v8), mv);
      chk("r8_idx",   int'(i8), mi);
      chk("r8_grant", int'(g8), (mv != 0) ? (1 << mi) : 0);
      s_v = v8;
      s_i = int'(i8);

      // New requests join the held ones; requesters keep lines up until accepted.
      hold   = hold | (8'($urandom) & 8'($urandom) & 8'($urandom));
      r8     = hold;
      rd8    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) m8 = ~m8;
      rst8_n = ($urandom_range(0, 999) != 0);

      @(posedge clk);
      model8_edge(r8, m8, rd8, rst8_n);

      // Starvation bound observed on the DUT's own grants.
      if (!rst8_n) begin
        g_mode = 1'b0;
        for (int c = 0; c < 8; c++) fcnt[c] = 0;
      end else begin
        acc8 = s_v && rd8;
        ld8  = !s_v || rd8;
        if (acc8) begin
          for (int c = 0; c < 8; c++) begin
            if (c == s_i) begin
              fcnt[c] = 0;
            end else if (g_mode && hold[c]) begin
              fcnt[c]++;
              chk("rr_wait_bound", int'(fcnt[c] <= 7), 1);
            end
          end
          hold[s_i] = 1'b0;
        end
        if (ld8) g_mode = m8;
        for (int c = 0; c < 8; c++) if (!hold[c]) fcnt[c] = 0;
      end
      @(negedge clk);
    end
    chk("r8_final_valid", int'(v8), mv);
    chk("r8_final_idx",   int'(i8), mi);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
